// File: rtl/lane_completion_unit_pkg.sv
// -----------------------------------------------------------------------------
// completion_pkg
// Shared decode constants and types for the lane completion unit.
//   - RV32M decode constants (opcode, funct7, funct3 of MUL/DIVU/REMU)
//   - lane_state_t : per-lane completion FSM states
//   - lat_class_t  : latency class of a dispatched instruction
//   - classify()   : maps an instruction word to its latency class
// -----------------------------------------------------------------------------
package completion_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] FUNCT7_M = 7'b0000001;
    localparam logic [2:0] F3_MUL   = 3'b000;
    localparam logic [2:0] F3_DIVU  = 3'b101;
    localparam logic [2:0] F3_REMU  = 3'b111;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        WB
    } lane_state_t;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MUL,
        CLS_DIV
    } lat_class_t;

    // zero_res marks an M-extension op this unit does not implement:
    // it completes in one cycle and writes 0.
    typedef struct packed {
        lat_class_t cls;
        logic       zero_res;
    } op_info_t;

    function automatic op_info_t classify(input logic [31:0] instr);
        op_info_t info;
        info.cls      = CLS_ALU;
        info.zero_res = 1'b0;
        if (instr[6:0] == OP_R && instr[31:25] == FUNCT7_M) begin
            case (instr[14:12])
                F3_MUL:           info.cls      = CLS_MUL;
                F3_DIVU, F3_REMU: info.cls      = CLS_DIV;
                default:          info.zero_res = 1'b1;
            endcase
        end
        return info;
    endfunction

endpackage

// File: rtl/lane_completion_unit_if.sv
// -----------------------------------------------------------------------------
// lane_completion_unit_if
// Dispatch / completion / writeback bundle between the scheduler side and the
// lane completion unit.
//   master : scheduler + datapaths (drive issue, operands, flush)
//   slave  : completion unit (drives ack, pending status, write strobes)
// -----------------------------------------------------------------------------
interface lane_completion_unit_if;

    logic        issue1, issue2;
    logic [31:0] instr1, instr2;
    logic [4:0]  regd1, regd2;
    logic [31:0] src_a1, src_b1, src_a2, src_b2;
    logic [31:0] alu_res1, alu_res2;
    logic        flush;

    logic        ack1, ack2;
    logic        pend1, pend2;
    logic [4:0]  pend_regd1, pend_regd2;
    logic        wb_en1, wb_en2;
    logic [4:0]  wb_regd1, wb_regd2;
    logic [31:0] wb_data1, wb_data2;

    modport master (
        output issue1, issue2, instr1, instr2, regd1, regd2,
               src_a1, src_b1, src_a2, src_b2, alu_res1, alu_res2, flush,
        input  ack1, ack2, pend1, pend2, pend_regd1, pend_regd2,
               wb_en1, wb_en2, wb_regd1, wb_regd2, wb_data1, wb_data2
    );

    modport slave (
        input  issue1, issue2, instr1, instr2, regd1, regd2,
               src_a1, src_b1, src_a2, src_b2, alu_res1, alu_res2, flush,
        output ack1, ack2, pend1, pend2, pend_regd1, pend_regd2,
               wb_en1, wb_en2, wb_regd1, wb_regd2, wb_data1, wb_data2
    );

endinterface

// File: rtl/lane_completion_unit_lane.sv
// -----------------------------------------------------------------------------
// completion_lane
// One issue lane: accepts a dispatched instruction, waits out its latency and
// presents a single-cycle register-file writeback.
// Ports:
//   clk, rst (async, active-low), flush
//   issue, instr, regd, src_a, src_b, alu_res : dispatch inputs
//   ack, pend, pend_regd                      : registered lane status
//   wb_en, wb_regd, wb_data                   : writeback (valid in WB only)
// -----------------------------------------------------------------------------
module completion_lane
    import completion_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        flush,
    input  logic        issue,
    input  logic [31:0] instr,
    input  logic [4:0]  regd,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic [31:0] alu_res,
    output logic        ack,
    output logic        pend,
    output logic [4:0]  pend_regd,
    output logic        wb_en,
    output logic [4:0]  wb_regd,
    output logic [31:0] wb_data
);

    localparam int MAX_LAT = (MUL_LATENCY > DIV_LATENCY) ? MUL_LATENCY : DIV_LATENCY;
    localparam int CNT_W   = $clog2(MAX_LAT);

    // BUSY holds L-1 cycles: the load value is L-2 and WB follows the cycle
    // in which the counter reads 0.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_LATENCY - 2);
    localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_LATENCY - 2);

    lane_state_t      state;
    logic [CNT_W-1:0] cnt;
    lat_class_t       cls_q;
    logic             zero_q;
    logic [2:0]       funct3_q;
    logic [4:0]       regd_q;
    logic [31:0]      a_q, b_q, alu_q;

    op_info_t    info;
    logic        accept;
    logic [31:0] result;

    assign info   = classify(instr);
    assign accept = issue && ack && !flush && (instr != '0);

    // NOTE: all state below is assigned with <= so every register samples the
    // pre-edge values; blocking assignments here would create order-dependent
    // races between the FSM and the operand latches.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b1;
            pend      <= 1'b0;
            pend_regd <= '0;
            // NOTE: the operand latches are reset only to keep the divider
            // inputs X-free; wb_data is gated by state, so it is not required
            // for correctness.
            cls_q     <= CLS_ALU;
            zero_q    <= 1'b0;
            funct3_q  <= '0;
            regd_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            alu_q     <= '0;
        end else if (flush) begin
            // A writeback presented this cycle still happens; only work that
            // would complete later is dropped.
            state     <= IDLE;
            cnt       <= '0;
            ack       <= 1'b1;
            pend      <= 1'b0;
            pend_regd <= '0;
        end else if (accept) begin
            cls_q     <= info.cls;
            zero_q    <= info.zero_res;
            funct3_q  <= instr[14:12];
            regd_q    <= regd;
            a_q       <= src_a;
            b_q       <= src_b;
            alu_q     <= alu_res;
            pend      <= 1'b1;
            pend_regd <= regd;
            case (info.cls)
                CLS_MUL: begin
                    state <= BUSY;
                    cnt   <= MUL_LOAD;
                    ack   <= 1'b0;
                end
                CLS_DIV: begin
                    state <= BUSY;
                    cnt   <= DIV_LOAD;
                    ack   <= 1'b0;
                end
                default: begin
                    state <= WB;
                    ack   <= 1'b1;
                end
            endcase
        end else begin
            case (state)
                BUSY: begin
                    if (cnt == '0) begin
                        state <= WB;
                        ack   <= 1'b1;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                WB: begin
                    state     <= IDLE;
                    pend      <= 1'b0;
                    pend_regd <= '0;
                end
                default: ;
            endcase
        end
    end

    // NOTE: result gets a default before the case so no path leaves it
    // unassigned and no latch is inferred.
    always_comb begin
        result = '0;
        case (cls_q)
            CLS_MUL: result = a_q * b_q;
            CLS_DIV: begin
                if (funct3_q == F3_REMU) begin
                    result = (b_q == '0) ? a_q : (a_q % b_q);
                end else begin
                    result = (b_q == '0) ? '1 : (a_q / b_q);
                end
            end
            default: result = zero_q ? '0 : alu_q;
        endcase
    end

    assign wb_en   = (state == WB) && (regd_q != '0);
    assign wb_regd = (state == WB) ? regd_q : '0;
    assign wb_data = (state == WB) ? result : '0;

endmodule

// File: rtl/lane_completion_unit.sv
// -----------------------------------------------------------------------------
// lane_completion_unit
// Completion and writeback responder for the two issue lanes. Each lane is an
// independent completion_lane; this level only fans out flush and resolves a
// same-register writeback collision in favour of lane 2 (younger instruction).
// Ports:
//   clk        : system clock
//   rst        : asynchronous active-low reset
//   bus        : lane_completion_unit_if.slave (dispatch in, ack/pend/wb out)
// -----------------------------------------------------------------------------
module lane_completion_unit
    import completion_pkg::*;
#(
    parameter int MUL_LATENCY = 3,
    parameter int DIV_LATENCY = 16
) (
    input logic                   clk,
    input logic                   rst,
    lane_completion_unit_if.slave bus
);

    logic wb_en1_raw;

    completion_lane #(
        .MUL_LATENCY(MUL_LATENCY),
        .DIV_LATENCY(DIV_LATENCY)
    ) u_lane1 (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .issue     (bus.issue1),
        .instr     (bus.instr1),
        .regd      (bus.regd1),
        .src_a     (bus.src_a1),
        .src_b     (bus.src_b1),
        .alu_res   (bus.alu_res1),
        .ack       (bus.ack1),
        .pend      (bus.pend1),
        .pend_regd (bus.pend_regd1),
        .wb_en     (wb_en1_raw),
        .wb_regd   (bus.wb_regd1),
        .wb_data   (bus.wb_data1)
    );

    completion_lane #(
        .MUL_LATENCY(MUL_LATENCY),
        .DIV_LATENCY(DIV_LATENCY)
    ) u_lane2 (
        .clk       (clk),
        .rst       (rst),
        .flush     (bus.flush),
        .issue     (bus.issue2),
        .instr     (bus.instr2),
        .regd      (bus.regd2),
        .src_a     (bus.src_a2),
        .src_b     (bus.src_b2),
        .alu_res   (bus.alu_res2),
        .ack       (bus.ack2),
        .pend      (bus.pend2),
        .pend_regd (bus.pend_regd2),
        .wb_en     (bus.wb_en2),
        .wb_regd   (bus.wb_regd2),
        .wb_data   (bus.wb_data2)
    );

    // Both ports writing the same register: the older lane-1 result is stale.
    assign bus.wb_en1 = wb_en1_raw && !(bus.wb_en2 && (bus.wb_regd1 == bus.wb_regd2));

endmodule

// File: tb/tb_lane_completion_unit.sv
// -----------------------------------------------------------------------------
// tb_lane_completion_unit
// Directed and random dispatch into both lanes. A reference model tracks, per
// lane, the cycle in which the accepted instruction writes back and queues the
// expected write; a negedge monitor compares status outputs every cycle and
// pops the write queue when a writeback is due.
// -----------------------------------------------------------------------------
module tb_lane_completion_unit;

    localparam int MUL_L = 3;
    localparam int DIV_L = 16;

    typedef struct {
        logic        iss;
        logic [31:0] ins;
        logic [4:0]  rd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] alu;
    } lane_in_t;

    typedef struct {
        int          cyc;
        logic [4:0]  regd;
        logic [31:0] data;
    } wb_exp_t;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    lane_completion_unit_if bus ();

    lane_completion_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int cyc = 0;
    always @(posedge clk) if (rst) cyc++;

    int         checks   = 0;
    int         failures = 0;
    int         snap_cyc = -1;
    int         due      [2];
    logic [4:0] pregd    [2];
    logic       exp_ack  [2];
    logic       exp_pend [2];
    logic [4:0] exp_pregd[2];
    wb_exp_t    wq       [2][$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic bit is_mop(input logic [31:0] ins);
        return ins[6:0] == 7'b0110011 && ins[31:25] == 7'b0000001;
    endfunction

    function automatic int latency_of(input logic [31:0] ins);
        if (is_mop(ins)) begin
            if (ins[14:12] == 3'b000) return MUL_L;
            if (ins[14:12] == 3'b101 || ins[14:12] == 3'b111) return DIV_L;
        end
        return 1;
    endfunction

    function automatic logic [31:0] result_of(input lane_in_t li);
        logic [63:0] p;
        if (!is_mop(li.ins)) return li.alu;
        case (li.ins[14:12])
            3'b000: begin
                p = {32'd0, li.a} * {32'd0, li.b};
                return p[31:0];
            end
            3'b101:  return (li.b == 0) ? 32'hFFFF_FFFF : li.a / li.b;
            3'b111:  return (li.b == 0) ? li.a : li.a % li.b;
            default: return 32'd0;
        endcase
    endfunction

    // ---------------- stimulus helpers ----------------
    function automatic lane_in_t mk(input logic iss, input logic [31:0] ins, input logic [4:0] rd,
                                    input logic [31:0] a, input logic [31:0] b, input logic [31:0] alu);
        lane_in_t li;
        li.iss = iss; li.ins = ins; li.rd = rd; li.a = a; li.b = b; li.alu = alu;
        return li;
    endfunction

    function automatic lane_in_t nop();
        return mk(1'b0, 32'd0, 5'd0, 32'd0, 32'd0, 32'd0);
    endfunction

    function automatic logic [31:0] mop(input logic [2:0] f3, input logic [4:0] rd);
        return {7'b0000001, 5'd2, 5'd1, f3, rd, 7'b0110011};
    endfunction

    function automatic logic [31:0] addi(input logic [4:0] rd);
        return {12'h001, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    function automatic lane_in_t rand_lane();
        lane_in_t    li;
        int          k = $urandom_range(0, 9);
        logic [31:0] r = $urandom;
        li.iss = ($urandom_range(0, 2) != 0);
        li.rd  = 5'($urandom_range(0, 7));
        li.a   = $urandom;
        li.b   = ($urandom_range(0, 3) == 0) ? 32'd0 : ($urandom >> $urandom_range(0, 24));
        li.alu = $urandom;
        case (k)
            0, 1, 2: li.ins = {r[24:0], 7'b0010011};
            3:       li.ins = {7'b0000000, r[9:0], r[12:10], li.rd, 7'b0110011};
            4:       li.ins = mop(3'b000, li.rd);
            5:       li.ins = mop(3'b101, li.rd);
            6:       li.ins = mop(3'b111, li.rd);
            7:       li.ins = mop(r[2:0], li.rd);
            8:       li.ins = 32'd0;
            default: li.ins = mop(3'b001, li.rd);
        endcase
        return li;
    endfunction

    // Drive one cycle of inputs, advance the model, then move to the next
    // cycle (returns 1 time unit after the following posedge).
    task automatic drive(input lane_in_t l1, input lane_in_t l2, input logic fl);
        lane_in_t li [2];
        wb_exp_t  e;
        li[0] = l1;
        li[1] = l2;
        bus.issue1 = l1.iss; bus.instr1 = l1.ins; bus.regd1 = l1.rd;
        bus.src_a1 = l1.a;   bus.src_b1 = l1.b;   bus.alu_res1 = l1.alu;
        bus.issue2 = l2.iss; bus.instr2 = l2.ins; bus.regd2 = l2.rd;
        bus.src_a2 = l2.a;   bus.src_b2 = l2.b;   bus.alu_res2 = l2.alu;
        bus.flush  = fl;
        for (int l = 0; l < 2; l++) begin
            exp_ack[l]   = (due[l] <= cyc);
            exp_pend[l]  = (due[l] >= cyc);
            exp_pregd[l] = exp_pend[l] ? pregd[l] : 5'd0;
            if (fl) begin
                while (wq[l].size() > 0 && wq[l][$].cyc > cyc) void'(wq[l].pop_back());
                if (due[l] > cyc) due[l] = -1;
            end else if (li[l].iss && exp_ack[l] && li[l].ins != 32'd0) begin
                due[l]   = cyc + latency_of(li[l].ins);
                pregd[l] = li[l].rd;
                if (li[l].rd != 5'd0) begin
                    e.cyc  = due[l];
                    e.regd = li[l].rd;
                    e.data = result_of(li[l]);
                    wq[l].push_back(e);
                end
            end
        end
        snap_cyc = cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(nop(), nop(), 1'b0);
    endtask

    task automatic clear_model();
        for (int l = 0; l < 2; l++) begin
            due[l]   = -1;
            pregd[l] = 5'd0;
            wq[l].delete();
        end
        snap_cyc = -1;
    endtask

    task automatic set_idle_inputs();
        bus.issue1 = 1'b0; bus.instr1 = '0; bus.regd1 = '0; bus.src_a1 = '0; bus.src_b1 = '0; bus.alu_res1 = '0;
        bus.issue2 = 1'b0; bus.instr2 = '0; bus.regd2 = '0; bus.src_a2 = '0; bus.src_b2 = '0; bus.alu_res2 = '0;
        bus.flush  = 1'b0;
    endtask

    task automatic release_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic reset_midway();
        snap_cyc = -1;
        #1 rst = 1'b0;
        #1;
        check("rst_ack1", bus.ack1, 1);
        check("rst_ack2", bus.ack2, 1);
        check("rst_pend1", bus.pend1, 0);
        check("rst_pend2", bus.pend2, 0);
        check("rst_pend_regd1", bus.pend_regd1, 0);
        check("rst_pend_regd2", bus.pend_regd2, 0);
        check("rst_wb_en1", bus.wb_en1, 0);
        check("rst_wb_en2", bus.wb_en2, 0);
        check("rst_wb_regd1", bus.wb_regd1, 0);
        check("rst_wb_regd2", bus.wb_regd2, 0);
        check("rst_wb_data1", bus.wb_data1, 0);
        check("rst_wb_data2", bus.wb_data2, 0);
        clear_model();
        set_idle_inputs();
        release_reset();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic        hit [2];
        logic        want;
        logic        coll;
        logic        a_ack [2], a_pend [2], a_en [2];
        logic [4:0]  a_pregd [2], a_regd [2];
        logic [31:0] a_data [2];
        if (rst && snap_cyc == cyc) begin
            a_ack   = '{bus.ack1, bus.ack2};
            a_pend  = '{bus.pend1, bus.pend2};
            a_pregd = '{bus.pend_regd1, bus.pend_regd2};
            a_en    = '{bus.wb_en1, bus.wb_en2};
            a_regd  = '{bus.wb_regd1, bus.wb_regd2};
            a_data  = '{bus.wb_data1, bus.wb_data2};
            for (int l = 0; l < 2; l++) begin
                check($sformatf("ack%0d", l + 1), a_ack[l], exp_ack[l]);
                check($sformatf("pend%0d", l + 1), a_pend[l], exp_pend[l]);
                check($sformatf("pend_regd%0d", l + 1), a_pregd[l], exp_pregd[l]);
                hit[l] = (wq[l].size() > 0) && (wq[l][0].cyc == cyc);
            end
            coll = hit[0] && hit[1] && (wq[0][0].regd == wq[1][0].regd);
            for (int l = 0; l < 2; l++) begin
                want = hit[l] && !(l == 0 && coll);
                check($sformatf("wb_en%0d", l + 1), a_en[l], want);
                if (want) begin
                    check($sformatf("wb_regd%0d", l + 1), a_regd[l], wq[l][0].regd);
                    check($sformatf("wb_data%0d", l + 1), a_data[l], wq[l][0].data);
                end
                if (hit[l]) void'(wq[l].pop_front());
            end
        end
    end

    // ---------------- sequence ----------------
    initial begin
        clear_model();
        set_idle_inputs();
        release_reset();

        // Single-cycle ALU, then back-to-back ALU issue on the same lane.
        drive(mk(1'b1, 32'h00208093, 5'd1, 32'd0, 32'd0, 32'd5), nop(), 1'b0);
        idle(2);
        drive(mk(1'b1, addi(5'd2), 5'd2, 32'd0, 32'd0, 32'd11), nop(), 1'b0);
        drive(mk(1'b1, addi(5'd6), 5'd6, 32'd0, 32'd0, 32'd12), nop(), 1'b0);
        idle(2);

        // MUL on lane 2: 7*6 into x3.
        drive(nop(), mk(1'b1, mop(3'b000, 5'd3), 5'd3, 32'd7, 32'd6, 32'd0), 1'b0);
        idle(4);

        // DIVU and REMU by zero.
        drive(mk(1'b1, mop(3'b101, 5'd5), 5'd5, 32'd9, 32'd0, 32'd0), nop(), 1'b0);
        idle(17);
        drive(mk(1'b1, mop(3'b111, 5'd5), 5'd5, 32'd9, 32'd0, 32'd0), nop(), 1'b0);
        idle(17);

        // Same-register collision: lane 2 wins.
        drive(mk(1'b1, addi(5'd4), 5'd4, 32'd0, 32'd0, 32'h11),
              mk(1'b1, addi(5'd4), 5'd4, 32'd0, 32'd0, 32'h22), 1'b0);
        idle(2);

        // Flush during DIVU BUSY: no writeback.
        drive(mk(1'b1, mop(3'b101, 5'd7), 5'd7, 32'd100, 32'd7, 32'd0), nop(), 1'b0);
        idle(3);
        drive(nop(), nop(), 1'b1);
        idle(2);

        // Flush with a simultaneous issue drops the issue.
        drive(mk(1'b1, addi(5'd8), 5'd8, 32'd0, 32'd0, 32'd33), nop(), 1'b1);
        idle(2);

        // Bubble.
        drive(nop(), mk(1'b1, 32'd0, 5'd9, 32'd0, 32'd0, 32'd44), 1'b0);
        idle(2);

        // Lane in WB during a flush still writes.
        drive(nop(), mk(1'b1, addi(5'd10), 5'd10, 32'd0, 32'd0, 32'd55), 1'b0);
        drive(nop(), nop(), 1'b1);
        idle(1);

        // Reset in the fifth cycle of a DIVU, then a MUL after release.
        drive(mk(1'b1, mop(3'b101, 5'd11), 5'd11, 32'd50, 32'd3, 32'd0), nop(), 1'b0);
        idle(4);
        reset_midway();
        drive(mk(1'b1, mop(3'b000, 5'd12), 5'd12, 32'd3, 32'd5, 32'd0), nop(), 1'b0);
        idle(4);

        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive(rand_lane(), rand_lane(), ($urandom_range(0, 24) == 0));
        end
        idle(20);

        check("drained", wq[0].size() + wq[1].size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
